// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the Z80 register page.
// Four-register CPU window: DATA (pop on read), STATUS, COUNT, CONTROL; sticky idle timeout.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       cpu_sel,
  input  logic [1:0] cpu_addr,
  input  logic       cpu_rd_n,
  input  logic       cpu_wr_n,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       rx_pending
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned TW    = 16;

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_HALF = CW'(DEPTH / 2);
  localparam logic [TW-1:0] T_LIMIT    = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_COUNT   = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          overflow, overflow_nxt;
  logic          timeout, timeout_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          rd_n_d, wr_n_d;

  logic empty, full, half;
  logic pop_edge, wr_edge, flush, clr_ovf, clr_to;
  logic do_pop, do_push, ovf_evt, tcnt_run, to_set;
  logic unused_din;

  assign unused_din = ^cpu_din[7:3];

  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);
  assign half  = (count >= COUNT_HALF);

  // Pop at the end of the read strobe so DATA stays stable during the Z80 read cycle.
  assign pop_edge = cpu_rd_n && !rd_n_d && cpu_sel && (cpu_addr == ADDR_DATA);
  assign wr_edge  = !cpu_wr_n && wr_n_d && cpu_sel && (cpu_addr == ADDR_CONTROL);
  assign flush    = wr_edge && cpu_din[0];
  assign clr_ovf  = wr_edge && cpu_din[1];
  assign clr_to   = wr_edge && cpu_din[2];

  assign do_pop   = pop_edge && !empty && !flush;
  assign do_push  = rx_valid && (!full || do_pop) && !flush;
  assign ovf_evt  = rx_valid && full && !do_pop && !flush;
  assign tcnt_run = !flush && !do_push && !empty;
  assign to_set   = tcnt_run && (tcnt == T_LIMIT - 16'd1);

  // Next-state logic for pointers, occupancy, flags and the idle counter.
  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count;
    overflow_nxt = overflow;
    timeout_nxt  = timeout;
    tcnt_nxt     = tcnt;

    if (flush) begin
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      count_nxt    = '0;
      overflow_nxt = 1'b0;
      timeout_nxt  = 1'b0;
      tcnt_nxt     = '0;
    end else begin
      if (do_push) wr_ptr_nxt = wr_ptr + PW'(1);
      if (do_pop)  rd_ptr_nxt = rd_ptr + PW'(1);
      count_nxt = count + CW'(do_push) - CW'(do_pop);

      if (ovf_evt)      overflow_nxt = 1'b1;
      else if (clr_ovf) overflow_nxt = 1'b0;

      if (to_set)      timeout_nxt = 1'b1;
      else if (clr_to) timeout_nxt = 1'b0;

      // A timeout clear restarts the idle count so the flag can re-arm within a burst.
      if (!tcnt_run)              tcnt_nxt = '0;
      else if (clr_to && !to_set) tcnt_nxt = '0;
      else if (tcnt != T_LIMIT)   tcnt_nxt = tcnt + 16'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
      tcnt     <= '0;
      rd_n_d   <= 1'b1;
      wr_n_d   <= 1'b1;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      overflow <= overflow_nxt;
      timeout  <= timeout_nxt;
      tcnt     <= tcnt_nxt;
      rd_n_d   <= cpu_rd_n;
      wr_n_d   <= cpu_wr_n;
    end
  end

  // Storage array is not reset; occupancy tracking makes stale entries invisible.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= rx_data;
  end

  // Zero-wait-state register read mux.
  always_comb begin
    cpu_dout = 8'h00;
    case (cpu_addr)
      ADDR_DATA:    cpu_dout = empty ? 8'h00 : mem[rd_ptr];
      ADDR_STATUS:  cpu_dout = {3'b000, half, timeout, overflow, full, empty};
      ADDR_COUNT:   cpu_dout = 8'(count);
      ADDR_CONTROL: cpu_dout = 8'h00;
      default:      cpu_dout = 8'h00;
    endcase
  end

  assign rx_pending = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized CPU/receiver traffic.
module tb_uart_rx_fifo;

  localparam int unsigned DL2   = 4;
  localparam int          DEPTH = 16;
  localparam int          TOUT  = 100;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       cpu_sel;
  logic [1:0] cpu_addr;
  logic       cpu_rd_n;
  logic       cpu_wr_n;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       rx_pending;

  int errors = 0;
  int checks = 0;
  bit rand_rx = 1'b0;
  bit cmp_en  = 1'b0;

  always #5 clk_sys = ~clk_sys;

  uart_rx_fifo #(.DEPTH_LOG2(DL2), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .cpu_sel(cpu_sel), .cpu_addr(cpu_addr), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .rx_pending(rx_pending)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus flags, advanced once per clock from the sampled inputs.
  logic [7:0] q[$];
  bit m_ovf  = 1'b0;
  bit m_to   = 1'b0;
  int m_tcnt = 0;
  bit m_rd_d = 1'b1;
  bit m_wr_d = 1'b1;

  always @(posedge clk_sys or negedge reset_n) begin : model
    bit pop_e, wr_e, was_empty, was_full, pop, push, set;
    int nt;
    if (!reset_n) begin
      q.delete();
      m_ovf = 0; m_to = 0; m_tcnt = 0; m_rd_d = 1; m_wr_d = 1;
    end else begin
      pop_e = cpu_rd_n && !m_rd_d && cpu_sel && (cpu_addr == 2'd0);
      wr_e  = !cpu_wr_n && m_wr_d && cpu_sel && (cpu_addr == 2'd3);
      if (wr_e && cpu_din[0]) begin
        q.delete();
        m_ovf = 0; m_to = 0; m_tcnt = 0;
      end else begin
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        pop  = pop_e && !was_empty;
        push = rx_valid && (!was_full || pop);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(rx_data);
        set = 0;
        if (push || was_empty) m_tcnt = 0;
        else begin
          nt  = (m_tcnt + 1 > TOUT) ? TOUT : m_tcnt + 1;
          set = (nt == TOUT) && (m_tcnt < TOUT);
          if (wr_e && cpu_din[2] && !set) nt = 0;
          m_tcnt = nt;
        end
        if (rx_valid && !push)       m_ovf = 1;
        else if (wr_e && cpu_din[1]) m_ovf = 0;
        if (set)                     m_to = 1;
        else if (wr_e && cpu_din[2]) m_to = 0;
      end
      m_rd_d = cpu_rd_n;
      m_wr_d = cpu_wr_n;
    end
  end

  function automatic logic [7:0] exp_dout(input logic [1:0] a);
    case (a)
      2'd0:    return (q.size() != 0) ? q[0] : 8'h00;
      2'd1:    return {3'b000, q.size() >= DEPTH / 2, m_to, m_ovf, q.size() == DEPTH, q.size() == 0};
      2'd2:    return 8'(q.size());
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clk_sys) begin
    if (cmp_en && reset_n === 1'b1) begin
      chk("dout_vs_model", cpu_dout, exp_dout(cpu_addr));
      chk("pending_vs_model", {7'd0, rx_pending}, {7'd0, q.size() != 0});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
      if (rand_rx) begin
        rx_valid = ($urandom_range(0, 2) == 0);
        rx_data  = 8'($urandom);
      end
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    cpu_addr = a;
    #1;
    d = cpu_dout;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    cpu_sel = 1'b1; cpu_addr = a; cpu_rd_n = 1'b0;
    tick(1);
    d = cpu_dout;
    cpu_rd_n = 1'b1;
    tick(1);
    cpu_sel = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    cpu_sel = 1'b1; cpu_addr = a; cpu_din = d; cpu_wr_n = 1'b0;
    tick(1);
    cpu_wr_n = 1'b1;
    tick(1);
    cpu_sel = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] wd;
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cpu_sel = 1'b0;
    cpu_addr = 2'd0; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_din = 8'h00;
    tick(3);
    peek(2'd0, d); chk("reset_data", d, 8'h00);
    peek(2'd1, d); chk("reset_status", d, 8'h01);
    chk("reset_pending", {7'd0, rx_pending}, 8'h00);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    tick(2);

    // Basic order
    push(8'hA5); push(8'h3C);
    peek(2'd2, d); chk("basic_count2", d, 8'h02);
    peek(2'd1, d); chk("basic_status", d, 8'h00);
    cpu_read(2'd0, d); chk("basic_pop1", d, 8'hA5);
    peek(2'd2, d); chk("basic_count1", d, 8'h01);
    cpu_read(2'd0, d); chk("basic_pop2", d, 8'h3C);
    peek(2'd1, d); chk("basic_status_empty", d, 8'h01);

    // Fill, overflow, clear
    for (int i = 0; i < 17; i++) begin
      rx_valid = 1'b1; rx_data = 8'(i);
      tick(1);
    end
    rx_valid = 1'b0;
    peek(2'd2, d); chk("fill_count", d, 8'h10);
    peek(2'd1, d); chk("fill_status", d, 8'h16);
    for (int i = 0; i < 16; i++) begin
      cpu_read(2'd0, d); chk("fill_order", d, 8'(i));
    end
    peek(2'd1, d); chk("drained_ovf_status", d, 8'h05);
    cpu_write(2'd3, 8'h02);
    peek(2'd1, d); chk("clr_ovf_status", d, 8'h01);

    // Push and pop in the same cycle while full
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    peek(2'd1, d); chk("full_status", d, 8'h12);
    cpu_sel = 1'b1; cpu_addr = 2'd0; cpu_rd_n = 1'b0;
    tick(1);
    cpu_rd_n = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
    tick(1);
    rx_valid = 1'b0; cpu_sel = 1'b0;
    peek(2'd2, d); chk("pushpop_count", d, 8'h10);
    peek(2'd1, d); chk("pushpop_status", d, 8'h12);
    for (int i = 1; i < 16; i++) begin
      cpu_read(2'd0, d); chk("pushpop_order", d, 8'(8'h40 + i));
    end
    cpu_read(2'd0, d); chk("pushpop_last", d, 8'hEE);

    // Idle timeout and re-arm after clear
    push(8'h77);
    for (int k = 1; k <= 100; k++) begin
      tick(1);
      if (k == 99)  begin peek(2'd1, d); chk("timeout_at_99", d, 8'h00); end
      if (k == 100) begin peek(2'd1, d); chk("timeout_at_100", d, 8'h08); end
    end
    cpu_write(2'd3, 8'h04);
    peek(2'd1, d); chk("timeout_cleared", d, 8'h00);
    for (int k = 2; k <= 100; k++) begin
      tick(1);
      if (k == 99)  begin peek(2'd1, d); chk("retimeout_at_99", d, 8'h00); end
      if (k == 100) begin peek(2'd1, d); chk("retimeout_at_100", d, 8'h08); end
    end
    cpu_read(2'd0, d); chk("timeout_data", d, 8'h77);
    cpu_write(2'd3, 8'h04);
    peek(2'd1, d); chk("empty_after_timeout", d, 8'h01);

    // Flush coinciding with a push
    push(8'h01); push(8'h02); push(8'h03);
    cpu_sel = 1'b1; cpu_addr = 2'd3; cpu_din = 8'h01; cpu_wr_n = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h99;
    tick(1);
    rx_valid = 1'b0; cpu_wr_n = 1'b1;
    tick(1);
    cpu_sel = 1'b0;
    peek(2'd2, d); chk("flush_count", d, 8'h00);
    peek(2'd1, d); chk("flush_status", d, 8'h01);
    chk("flush_pending", {7'd0, rx_pending}, 8'h00);
    cpu_read(2'd0, d); chk("empty_pop_data", d, 8'h00);
    peek(2'd2, d); chk("empty_pop_count", d, 8'h00);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
    for (int i = 0; i < 11; i++) cpu_read(2'd0, d);
    peek(2'd2, d); chk("prereset_count", d, 8'h05);
    peek(2'd1, d); chk("prereset_status", d, 8'h04);
    cpu_sel = 1'b1; cpu_addr = 2'd0; cpu_rd_n = 1'b1;
    @(posedge clk_sys); #2;
    reset_n = 1'b0;
    #1;
    peek(2'd2, d); chk("async_reset_count", d, 8'h00);
    peek(2'd1, d); chk("async_reset_status", d, 8'h01);
    chk("async_reset_pending", {7'd0, rx_pending}, 8'h00);
    @(posedge clk_sys); #1;
    cpu_addr = 2'd0;
    reset_n = 1'b1;
    tick(3);
    peek(2'd2, d); chk("post_reset_count", d, 8'h00);
    cpu_sel = 1'b0;
    push(8'h5A);
    peek(2'd2, d); chk("post_reset_push_count", d, 8'h01);
    cpu_read(2'd0, d); chk("post_reset_data", d, 8'h5A);

    // Randomized traffic against the model
    rand_rx = 1'b1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: tick(1);
        4, 5, 6:    cpu_read(2'd0, d);
        7:          cpu_read(2'($urandom_range(0, 3)), d);
        8: begin
          wd = 8'($urandom);
          if ($urandom_range(0, 7) != 0) wd[0] = 1'b0;
          cpu_write(2'($urandom_range(0, 3)), wd);
        end
        default: begin
          rand_rx = 1'b0; rx_valid = 1'b0;
          tick($urandom_range(1, 150));
          rand_rx = 1'b1;
        end
      endcase
    end
    rand_rx = 1'b0; rx_valid = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver (`async_receiver`) and the Z80 register page in `system`. It captures each byte the receiver strobes out into a DEPTH-entry FIFO, so the firmware no longer loses bytes that arrive faster than it polls the single `rxd_ready_flag`. The CPU sees a four-register window: data (pop on read), status, count, and control. A sticky idle-timeout flag marks the end of a burst.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth = 2^DEPTH_LOG2 entries; legal range 1..7.
- `TIMEOUT_CYCLES`, default 20000: clk_sys cycles of receive silence, with FIFO non-empty, before the timeout flag sets; legal range 1..65535.
- `clk_sys`  in  1  system clock; all state on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle pulse from the receiver; byte on `rx_data` is valid.
- `rx_data`  in  8  received byte.
- `cpu_sel`  in  1  register page selected by the parent (address decode && !mreq_n).
- `cpu_addr`  in  2  register index: 0 DATA, 1 STATUS, 2 COUNT, 3 CONTROL.
- `cpu_rd_n`  in  1  Z80 read strobe, active-low.
- `cpu_wr_n`  in  1  Z80 write strobe, active-low.
- `cpu_din`  in  8  CPU write data.
- `cpu_dout`  out  8  register read data, combinational from `cpu_addr` and state.
- `rx_pending`  out  1  high whenever the FIFO is non-empty.

## Operation
- **Storage:** 2^DEPTH_LOG2 × 8 register array, `wr_ptr`/`rd_ptr` of DEPTH_LOG2 bits, `count` of DEPTH_LOG2+1 bits. Pointers wrap modulo depth.
- **Push:** on `rx_valid`, if `count` < depth (or a pop occurs the same cycle), write `rx_data` at `wr_ptr`, then `wr_ptr`+1.
- **Overflow:** on `rx_valid` with the FIFO full and no simultaneous pop, drop the byte and set sticky `overflow`.
- **Pop:** fires on the rising edge of `cpu_rd_n`, detected as `cpu_rd_n` high while registered `rd_n_d` is low, qualified by `cpu_sel` && `cpu_addr`==0. Popping at the end of the read strobe keeps DATA stable for the whole Z80 read.
  - Pop when empty: no effect.
- **Simultaneous push and pop:**
  - Both pointers advance; `count` is unchanged.
  - When full, no overflow.
  - When empty, the push proceeds and the pop is ignored.
- **Register reads:**
  - DATA = `mem[rd_ptr]` when non-empty, else 8'h00.
  - STATUS = {3'b0, half, timeout, overflow, full, empty}, where half = `count` ≥ depth/2.
  - COUNT = `count`, zero-extended.
  - CONTROL reads 8'h00.
- **CONTROL writes:** act on the falling edge of `cpu_wr_n`, detected as `cpu_wr_n` low while registered `wr_n_d` is high, qualified by `cpu_sel` && `cpu_addr`==3. Exactly one action per Z80 write.
  - bit0 flush: pointers and count go to 0, and overflow and timeout clear.
  - bit1 clears overflow.
  - bit2 clears timeout.
  - Writes to addresses 0–2 are ignored.
- **Flush priority:** flush wins over a same-cycle push (the byte is discarded) and over a same-cycle pop.
- **Clear priority:** a same-cycle overflow event or timeout-set event wins over bit1/bit2 clear, so the flag stays set.
- **Idle-timeout counter:** 16 bits.
  - Reset to 0 on every accepted push, on flush, and whenever the FIFO is empty.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES, sticky `timeout` sets.
  - Firmware treats `timeout` as end-of-burst.

## Timing
- **Reset values:** pointers, `count`, `overflow`, `timeout`, and the timeout counter are 0. `rd_n_d` and `wr_n_d` reset to 1, so no false edge after reset. `cpu_dout` = 8'h00 at addr 0. `rx_pending` = 0.
- **Push latency:** `rx_valid` in cycle N → `count`, `rx_pending`, and the DATA/STATUS/COUNT read values updated in cycle N+1.
- **Pop latency:** `cpu_rd_n` rises in cycle N (edge seen at that clock against `rd_n_d`) → `rd_ptr` and `count` updated in cycle N+1.
- **Control latency:** `cpu_wr_n` falls in cycle N → flag and pointer changes visible in cycle N+1.
- **Timeout latency:** `timeout` sets exactly TIMEOUT_CYCLES cycles after the last accepted push. This assumes the FIFO stays non-empty.
- **Reset mid-operation:** asserting `reset_n` low at any time immediately returns all state to its reset values. The FIFO contents (register array) need not be reset.
- **Read path:** `cpu_dout` is combinational with no wait states; it must meet a single-clk_sys read path into the `cpu_din` mux.

## Test plan
- **Basic FIFO order:** reset, push 8'hA5, 8'h3C → COUNT=2, STATUS=8'h00. Read DATA → 8'hA5; COUNT=1 after the rd_n rising edge. Read DATA → 8'h3C; STATUS=8'h01.
- **Fill, overflow, clear:** DEPTH_LOG2=4; push 17 bytes 0..16 → COUNT=16, STATUS=8'h16 (full, overflow, half). 16 pops return 0..15. Write CONTROL=8'h02 → STATUS=8'h01.
- **Push+pop when full:** with the FIFO full, `rx_valid` lands in the same cycle as a pop edge → COUNT stays 16, overflow stays 0, the last entry equals the new byte.
- **Timeout:** TIMEOUT_CYCLES=100; push one byte → timeout bit = 0 at cycle 99 after the push and 1 at cycle 100. Write CONTROL=8'h04 → timeout bit clears, then re-sets 100 cycles later (FIFO still non-empty).
- **Flush vs push:** flush write coincides with `rx_valid` → COUNT=0, STATUS=8'h01, `rx_pending`=0. A pop on empty leaves COUNT=0 and DATA=8'h00.
- **Async reset mid-burst:** pull `reset_n` low between clocks with COUNT=5 and overflow set → COUNT=0 and STATUS=8'h01 immediately, and no spurious pop after reset release while `cpu_rd_n` is held high.
